// File: rtl/fp_pkg.sv
// Shared types and widths for the unsigned same-exponent floating-point
// subtractor: field widths, the packed {exp, mant} result word and the
// normalisation FSM state encoding.
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;

    typedef struct packed {
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } fp_word_t;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        DONE
    } sub_state_e;

endpackage

// File: rtl/unsigned_floating_point_subtractor_if.sv
// Operand/result handshake bundle for the subtractor.
//   in_valid/in_ready, a_mant, b_mant, exp : operand side
//   out_valid/out_ready, out, out_sign     : result side
// slave  : the subtractor
// master : the environment driving operands and consuming results
interface unsigned_floating_point_subtractor_if;
    import fp_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [MANT_W:0]        a_mant;
    logic [MANT_W:0]        b_mant;
    logic [EXP_W-1:0]       exp;
    logic                   out_valid;
    logic                   out_ready;
    logic [EXP_W+MANT_W-1:0] out;
    logic                   out_sign;

    modport slave (
        input  in_valid, a_mant, b_mant, exp, out_ready,
        output in_ready, out_valid, out, out_sign
    );

    modport master (
        output in_valid, a_mant, b_mant, exp, out_ready,
        input  in_ready, out_valid, out, out_sign
    );

endinterface

// File: rtl/fp_mant_abs_diff.sv
// Combinational magnitude difference of two mantissas (hidden bit explicit).
//   a, b : mantissas
//   diff : |a - b|
//   swap : 1 when b > a (operands were swapped to keep the result positive)
module fp_mant_abs_diff
    import fp_pkg::*;
(
    input  logic [MANT_W:0] a,
    input  logic [MANT_W:0] b,
    output logic [MANT_W:0] diff,
    output logic            swap
);

    always_comb begin
        swap = (b > a);
        diff = swap ? (b - a) : (a - b);
    end

endmodule

// File: rtl/unsigned_floating_point_subtractor.sv
// |a - b| of two mantissas sharing one exponent, renormalised by one left
// shift per cycle. Result is {exp, mant} plus a sign flag (1 when b > a).
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : operand/result valid-ready handshake (slave side)
//
// state | meaning
// IDLE  | ready for operands
// NORM  | shifting the difference left until the hidden bit is set
// DONE  | result presented, waiting for out_ready
module unsigned_floating_point_subtractor
    import fp_pkg::*;
(
    input  logic                                 clk,
    input  logic                                 rst_n,
    unsigned_floating_point_subtractor_if.slave  bus
);

    sub_state_e        state_q, state_d;
    logic [MANT_W:0]   diff_q, diff_d;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic              sign_q, sign_d;
    fp_word_t          out_q, out_d;
    logic              out_sign_q, out_sign_d;

    logic [MANT_W:0]   abs_diff;
    logic              swap;

    fp_mant_abs_diff u_abs_diff (
        .a    (bus.a_mant),
        .b    (bus.b_mant),
        .diff (abs_diff),
        .swap (swap)
    );

    always_comb begin
        state_d    = state_q;
        diff_d     = diff_q;
        exp_d      = exp_q;
        sign_d     = sign_q;
        out_d      = out_q;
        out_sign_d = out_sign_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    diff_d  = abs_diff;
                    exp_d   = bus.exp;
                    sign_d  = swap;
                    state_d = NORM;
                end
            end
            NORM: begin
                if (diff_q == '0) begin
                    // Exact cancellation is reported as positive zero.
                    out_d      = '0;
                    out_sign_d = 1'b0;
                    state_d    = DONE;
                end else if (exp_q == '0) begin
                    out_d      = '{exp: '0, mant: diff_q[MANT_W-1:0]};
                    out_sign_d = sign_q;
                    state_d    = DONE;
                end else if (diff_q[MANT_W]) begin
                    out_d      = '{exp: exp_q, mant: diff_q[MANT_W-1:0]};
                    out_sign_d = sign_q;
                    state_d    = DONE;
                end else if (exp_q == EXP_W'(1)) begin
                    // Cannot shift further without leaving the normal range:
                    // emit a denormal. This stop also keeps exp_q from wrapping.
                    out_d      = '{exp: '0, mant: diff_q[MANT_W-1:0]};
                    out_sign_d = sign_q;
                    state_d    = DONE;
                end else begin
                    diff_d = {diff_q[MANT_W-1:0], 1'b0};
                    exp_d  = exp_q - EXP_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            diff_q     <= '0;
            exp_q      <= '0;
            sign_q     <= 1'b0;
            out_q      <= '0;
            out_sign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            diff_q     <= diff_d;
            exp_q      <= exp_d;
            sign_q     <= sign_d;
            out_q      <= out_d;
            out_sign_q <= out_sign_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out       = out_q;
    assign bus.out_sign  = out_sign_q;

endmodule

// File: tb/tb_unsigned_floating_point_subtractor.sv
module tb_unsigned_floating_point_subtractor;

    typedef struct {
        logic [30:0] out;
        logic        sign;
        int          lat;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    exp_t sb[$];

    unsigned_floating_point_subtractor_if bus ();

    unsigned_floating_point_subtractor dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Independent reference: shift while normal range allows, then pack.
    task automatic model(input logic [23:0] a, input logic [23:0] b, input logic [7:0] e,
                         output logic [30:0] o, output logic s, output int lat);
        logic [23:0] d;
        logic [7:0]  ee;
        int          k;
        s  = (b > a);
        d  = s ? b - a : a - b;
        ee = e;
        k  = 0;
        while (d != 0 && ee > 1 && !d[23]) begin
            d  = d << 1;
            ee = ee - 1;
            k++;
        end
        if (d == 0) begin
            o = '0;
            s = 1'b0;
        end else if (d[23] && ee != 0) begin
            o = {ee, d[22:0]};
        end else begin
            o = {8'h00, d[22:0]};
        end
        lat = k + 1;
    endtask

    task automatic do_op(input logic [23:0] a, input logic [23:0] b, input logic [7:0] e,
                         input logic [30:0] eo, input logic es, input int elat,
                         input int stall, input bit junk);
        exp_t        x;
        exp_t        got;
        int          n;
        logic [30:0] held;
        x.out = eo; x.sign = es; x.lat = elat;
        sb.push_back(x);
        @(negedge clk);
        check("in_ready_idle", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.a_mant   = a;
        bus.b_mant   = b;
        bus.exp      = e;
        @(posedge clk);
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.out_valid) begin
                bus.in_valid = 1'b0;
                break;
            end
            if (junk) begin
                bus.in_valid = 1'b1;
                bus.a_mant   = 24'h123456;
                bus.b_mant   = 24'hFEDCBA;
                bus.exp      = 8'h55;
            end else begin
                bus.in_valid = 1'b0;
            end
            if (n == 0) check("in_ready_busy", 64'(bus.in_ready), 64'd0);
            @(posedge clk);
            n++;
            if (n > 40) begin
                check("timeout_out_valid", 64'(n), 64'(elat));
                bus.in_valid = 1'b0;
                break;
            end
        end
        got = sb.pop_front();
        check("out", 64'(bus.out), 64'(got.out));
        check("out_sign", 64'(bus.out_sign), 64'(got.sign));
        check("latency", 64'(n), 64'(got.lat));
        held = bus.out;
        for (int i = 0; i < stall; i++) begin
            bus.out_ready = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check("stall_valid", 64'(bus.out_valid), 64'd1);
            check("stall_out", 64'(bus.out), 64'(held));
            check("stall_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("post_hs_valid", 64'(bus.out_valid), 64'd0);
        check("post_hs_in_ready", 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        logic [30:0] mo;
        logic        ms;
        int          ml;
        logic [23:0] ra, rb;
        logic [7:0]  re;
        total = 0;
        bad   = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a_mant    = '0;
        bus.b_mant    = '0;
        bus.exp       = '0;
        rst_n = 1'b0;
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out", 64'(bus.out), 64'd0);
        check("rst_out_sign", 64'(bus.out_sign), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_op(24'hC00000, 24'h800000, 8'h80, 31'h3F800000, 1'b0, 2, 0, 0);
        do_op(24'h800000, 24'hC00000, 8'h80, 31'h3F800000, 1'b1, 2, 0, 1);
        do_op(24'hABCDEF, 24'hABCDEF, 8'h90, 31'h0, 1'b0, 1, 0, 0);
        do_op(24'h800001, 24'h800000, 8'hFE, {8'hE7, 23'h0}, 1'b0, 24, 0, 1);
        do_op(24'h800001, 24'h800000, 8'h03, {8'h00, 23'h000004}, 1'b0, 3, 5, 0);
        do_op(24'h900000, 24'h800000, 8'h00, {8'h00, 23'h100000}, 1'b0, 1, 0, 0);
        do_op(24'h800000, 24'hC00000, 8'h01, {8'h00, 23'h400000}, 1'b1, 1, 2, 0);

        // Abort mid-normalisation.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a_mant   = 24'h800001;
        bus.b_mant   = 24'h800000;
        bus.exp      = 8'hFE;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_norm_in_ready", 64'(bus.in_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 64'(bus.out_valid), 64'd0);
        check("abort_out", 64'(bus.out), 64'd0);
        check("abort_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(24'hC00000, 24'h800000, 8'h80, 31'h3F800000, 1'b0, 2, 0, 0);

        for (int i = 0; i < 6; i++) begin
            ra = 24'h800000 | 24'($urandom);
            rb = 24'h800000 | 24'($urandom);
            re = 8'($urandom_range(1, 254));
            model(ra, rb, re, mo, ms, ml);
            do_op(ra, rb, re, mo, ms, ml, i % 3, i[0]);
        end

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
